// File: rtl/i2s_receiver.sv
// I2S receiver: synchronizes sck/ws/sd into clk_in and deserializes MSB-first
// channel words into parallel PCM samples with a one-cycle valid pulse.
module i2s_receiver #(
   parameter int unsigned SAMPLE_WIDTH = 24,
   parameter int unsigned SLOT_WIDTH   = 32
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    sck,
   input  logic                    ws,
   input  logic                    sd,
   output logic [SAMPLE_WIDTH-1:0] sample_out,
   output logic                    sample_valid,
   output logic                    sample_channel
);

   localparam int unsigned IDX_W = $clog2(SLOT_WIDTH + 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(SLOT_WIDTH);
   localparam logic [IDX_W-1:0] IDX_CAP = IDX_W'(SAMPLE_WIDTH);
   localparam logic [IDX_W-1:0] IDX_LSB = IDX_W'(SAMPLE_WIDTH - 1);

   logic [1:0]              sck_sync;
   logic [1:0]              ws_sync;
   logic [1:0]              sd_sync;
   logic                    sck_s;
   logic                    ws_s;
   logic                    sd_s;
   logic                    sck_prev;
   logic                    ws_d;
   logic                    ws_dd;
   logic                    locked;
   logic [IDX_W-1:0]        bit_idx;
   logic [SAMPLE_WIDTH-1:0] shift_reg;

   logic                    sck_rise;
   logic                    ws_edge;
   logic [IDX_W-1:0]        idx_next;
   logic [SAMPLE_WIDTH-1:0] shift_next;
   logic                    word_done;

   assign sck_s = sck_sync[1];
   assign ws_s  = ws_sync[1];
   assign sd_s  = sd_sync[1];

   // Bit position of the current rise; a WS change restarts the word at the MSB.
   always_comb begin
      sck_rise   = sck_s & ~sck_prev;
      ws_edge    = ws_d ^ ws_dd;
      idx_next   = bit_idx;
      shift_next = {shift_reg[SAMPLE_WIDTH-2:0], sd_s};
      if (ws_edge) begin
         idx_next = '0;
      end else if (bit_idx != IDX_MAX) begin
         idx_next = bit_idx + IDX_W'(1);
      end
      word_done = sck_rise & (locked | ws_edge) & (idx_next == IDX_LSB);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sck_sync       <= '0;
         ws_sync        <= '0;
         sd_sync        <= '0;
         sck_prev       <= 1'b0;
         ws_d           <= 1'b0;
         ws_dd          <= 1'b0;
         locked         <= 1'b0;
         bit_idx        <= '0;
         shift_reg      <= '0;
         sample_out     <= '0;
         sample_valid   <= 1'b0;
         sample_channel <= 1'b0;
      end else begin
         sck_sync     <= {sck_sync[0], sck};
         ws_sync      <= {ws_sync[0], ws};
         sd_sync      <= {sd_sync[0], sd};
         sck_prev     <= sck_s;
         sample_valid <= 1'b0;
         if (sck_rise) begin
            ws_d    <= ws_s;
            ws_dd   <= ws_d;
            bit_idx <= idx_next;
            if (ws_edge) begin
               locked <= 1'b1;
            end
            if (idx_next < IDX_CAP) begin
               shift_reg <= shift_next;
            end
            if (word_done) begin
               sample_out     <= shift_next;
               sample_channel <= ws_d;
               sample_valid   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: table-driven stereo words plus
// hand-written reset, lock and short-word sequences, checked via a scoreboard.
module tb_i2s_receiver;

   localparam int unsigned SW   = 24;
   localparam int unsigned SLOT = 32;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b1;
   logic          sck    = 1'b0;
   logic          ws     = 1'b0;
   logic          sd     = 1'b0;
   logic [SW-1:0] sample_out;
   logic          sample_valid;
   logic          sample_channel;

   i2s_receiver #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SLOT)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .sck            (sck),
      .ws             (ws),
      .sd             (sd),
      .sample_out     (sample_out),
      .sample_valid   (sample_valid),
      .sample_channel (sample_channel)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic          ch;
      logic [SW-1:0] data;
      logic          pad;
   } vec_t;

   typedef struct {
      logic          ch;
      logic [SW-1:0] data;
      int            lsb_cyc;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[10];
   int   checks    = 0;
   int   errors    = 0;
   int   cyc       = 0;
   int   pulse_cnt = 0;
   int   half      = 8;
   int   p0;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One I2S slot: period 0 carries the previous slot's last bit, MSB follows.
   task automatic send_slot(input logic ch, input logic [SW-1:0] data, input int len,
                            input logic pad, input bit expect_word);
      logic b;
      exp_t e;
      for (int p = 0; p < len; p++) begin
         b = pad;
         if (p >= 1 && p <= int'(SW)) b = data[int'(SW) - p];
         sck = 1'b0;
         ws  = ch;
         sd  = b;
         repeat (half) @(negedge clk_in);
         sck = 1'b1;
         if (p == int'(SW) && expect_word) begin
            e.ch      = ch;
            e.data    = data;
            e.lsb_cyc = cyc;
            sb.push_back(e);
         end
         repeat (half) @(negedge clk_in);
      end
   endtask

   // Scoreboard: every pulse must match the oldest expected word and its latency.
   always @(posedge clk_in) begin
      exp_t e;
      #1;
      if (sample_valid) begin
         pulse_cnt++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got out=0x%0h ch=%0d expected no pulse",
                     sample_out, sample_channel);
         end else begin
            e = sb.pop_front();
            check("pulse_data", 32'(sample_out), 32'(e.data));
            check("pulse_channel", 32'(sample_channel), 32'(e.ch));
            check("pulse_latency", 32'(cyc - e.lsb_cyc), 32'd3);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 24'hA5C3F0, 1'b0};
      vecs[1] = '{1'b1, 24'h800001, 1'b1};
      for (int i = 0; i < 4; i++) begin
         vecs[2 + 2*i] = '{1'b0, SW'(i + 1), 1'b0};
         vecs[3 + 2*i] = '{1'b1, 24'hFFFFF0 + SW'(i), 1'b0};
      end

      // Reset with sck toggling, then ws held 0: no lock, no pulse.
      half = 16;
      send_slot(1'b0, '0, 4, 1'b0, 1'b0);
      check("reset_valid", 32'(sample_valid), 32'd0);
      check("reset_out", 32'(sample_out), 32'd0);
      check("reset_channel", 32'(sample_channel), 32'd0);
      rst_in = 1'b0;
      send_slot(1'b0, 24'h5AA55A, 100, 1'b1, 1'b0);
      check("nolock_pulses", 32'(pulse_cnt), 32'd0);
      check("nolock_out", 32'(sample_out), 32'd0);
      check("nolock_channel", 32'(sample_channel), 32'd0);

      // Short right stretch (dropped), then the table of full stereo words.
      half = 8;
      send_slot(1'b1, 24'hFFFFFF, 5, 1'b1, 1'b0);
      check("short_lock_pulses", 32'(pulse_cnt), 32'd0);
      p0 = pulse_cnt;
      for (int i = 0; i < 10; i++) begin
         send_slot(vecs[i].ch, vecs[i].data, SLOT, vecs[i].pad, 1'b1);
         check("hold_out", 32'(sample_out), 32'(vecs[i].data));
         check("hold_channel", 32'(sample_channel), 32'(vecs[i].ch));
         check("pulse_count", 32'(pulse_cnt - p0), 32'(i + 1));
      end

      // Short left word after 10 bits, then a full right word.
      p0 = pulse_cnt;
      send_slot(1'b0, 24'hFFFFFF, 11, 1'b0, 1'b0);
      send_slot(1'b1, 24'h123456, SLOT, 1'b0, 1'b1);
      check("short_word_pulses", 32'(pulse_cnt - p0), 32'd1);
      check("short_word_out", 32'(sample_out), 32'h123456);

      // Reset for one cycle at bit 12 of a left word.
      send_slot(1'b0, 24'hFFFFFF, 13, 1'b0, 1'b0);
      sck = 1'b0;
      sd  = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      check("midreset_out", 32'(sample_out), 32'd0);
      check("midreset_valid", 32'(sample_valid), 32'd0);
      check("midreset_channel", 32'(sample_channel), 32'd0);
      repeat (half - 2) @(negedge clk_in);
      sck = 1'b1;
      repeat (half) @(negedge clk_in);
      p0 = pulse_cnt;
      send_slot(1'b0, 24'hFFFFFF, 18, 1'b1, 1'b0);
      check("midreset_pulses", 32'(pulse_cnt - p0), 32'd0);
      send_slot(1'b1, 24'h5A5A5A, SLOT, 1'b0, 1'b1);
      send_slot(1'b0, 24'h0F0F0F, SLOT, 1'b0, 1'b1);
      check("relock_pulses", 32'(pulse_cnt - p0), 32'd2);

      repeat (50) @(negedge clk_in);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
